// File: rtl/draw_arbiter.sv
// Round-robin arbiter that multiplexes three drawing clients onto one VGA adapter port.
// One client holds the grant until done, request drop or hold timeout; outputs are registered.
module draw_arbiter #(
  parameter logic [15:0] TIMEOUT = 16'd20000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  done,
  input  logic [2:0]  plotIn,
  input  logic [23:0] xIn,
  input  logic [20:0] yIn,
  input  logic [8:0]  colourIn,
  output logic [2:0]  grant,
  output logic [7:0]  xout,
  output logic [6:0]  yout,
  output logic [2:0]  colourOut,
  output logic        plot,
  output logic        busy,
  output logic        timeoutErr
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t      state, state_next;
  logic [1:0]  g, last_ptr, winner;
  logic [1:0]  c0, c1, c2;
  logic [15:0] hold;
  logic        found, to_err;
  logic        sel_req, sel_done, sel_plot;
  logic [7:0]  sel_x;
  logic [6:0]  sel_y;
  logic [2:0]  sel_c;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      default: return v[2];
    endcase
  endfunction

  // Round-robin search starts just after the last client served.
  always_comb begin
    c0     = next_idx(last_ptr);
    c1     = next_idx(c0);
    c2     = next_idx(c1);
    found  = |req;
    winner = bit_at(req, c0) ? c0 : (bit_at(req, c1) ? c1 : c2);
  end

  always_comb begin
    sel_req  = bit_at(req, g);
    sel_done = bit_at(done, g);
    sel_plot = bit_at(plotIn, g);
    case (g)
      2'd0: begin
        sel_x = xIn[7:0];
        sel_y = yIn[6:0];
        sel_c = colourIn[2:0];
      end
      2'd1: begin
        sel_x = xIn[15:8];
        sel_y = yIn[13:7];
        sel_c = colourIn[5:3];
      end
      default: begin
        sel_x = xIn[23:16];
        sel_y = yIn[20:14];
        sel_c = colourIn[8:6];
      end
    endcase
  end

  // done outranks the timeout so a client finishing on the last allowed cycle is not flagged.
  always_comb begin
    state_next = state;
    to_err     = 1'b0;
    case (state)
      IDLE: begin
        if (found) state_next = GRANT;
      end
      GRANT: begin
        if (sel_done) begin
          state_next = RELEASE;
        end else if (hold == TIMEOUT - 16'd1) begin
          state_next = RELEASE;
          to_err     = 1'b1;
        end else if (!sel_req) begin
          state_next = RELEASE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    grant = '0;
    if (state == GRANT) begin
      case (g)
        2'd0:    grant = 3'b001;
        2'd1:    grant = 3'b010;
        default: grant = 3'b100;
      endcase
    end
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      g          <= '0;
      last_ptr   <= 2'd2;
      hold       <= '0;
      xout       <= '0;
      yout       <= '0;
      colourOut  <= '0;
      plot       <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state <= state_next;
      plot  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            g    <= winner;
            hold <= '0;
          end
        end
        GRANT: begin
          hold      <= hold + 16'd1;
          xout      <= sel_x;
          yout      <= sel_y;
          colourOut <= sel_c;
          plot      <= sel_plot;
        end
        default: last_ptr <= g;
      endcase
      if (to_err) timeoutErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_draw_arbiter.sv
// Bench for draw_arbiter: a cycle model feeds a scoreboard queue, plus directed scenario checks.
module tb_draw_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req = '0, done = '0, plotIn = '0;
  logic [23:0] xIn = '0;
  logic [20:0] yIn = '0;
  logic [8:0]  colourIn = '0;
  logic [2:0]  grant, colourOut;
  logic [7:0]  xout;
  logic [6:0]  yout;
  logic        plot, busy, timeoutErr;

  int n_checks = 0;
  int n_errors = 0;

  draw_arbiter #(.TIMEOUT(16'(TO))) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .plotIn(plotIn),
    .xIn(xIn), .yIn(yIn), .colourIn(colourIn), .grant(grant), .xout(xout),
    .yout(yout), .colourOut(colourOut), .plot(plot), .busy(busy), .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 granted, 2 releasing.
  int          m_state = 0, m_g = 0, m_last = 2;
  int unsigned m_hold = 0;
  logic        m_plot = 0, m_err = 0;
  logic [7:0]  m_x = '0;
  logic [6:0]  m_y = '0;
  logic [2:0]  m_c = '0;
  logic [23:0] sb[$];

  task automatic model_step();
    if (reset) begin
      m_state = 0; m_g = 0; m_last = 2; m_hold = 0;
      m_plot = 0; m_x = '0; m_y = '0; m_c = '0; m_err = 0;
    end else begin
      case (m_state)
        0: begin
          m_plot = 0;
          for (int k = 1; k <= 3; k++) begin
            int ci;
            ci = (m_last + k) % 3;
            if (m_state == 0 && req[ci]) begin
              m_g = ci; m_state = 1; m_hold = 0;
            end
          end
        end
        1: begin
          m_x = 8'(xIn >> (8 * m_g));
          m_y = 7'(yIn >> (7 * m_g));
          m_c = 3'(colourIn >> (3 * m_g));
          m_plot = plotIn[m_g];
          if (done[m_g]) m_state = 2;
          else if (m_hold == TO - 1) begin m_state = 2; m_err = 1; end
          else if (!req[m_g]) m_state = 2;
          m_hold++;
        end
        default: begin
          m_last = m_g; m_state = 0; m_plot = 0;
        end
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_step();
    sb.push_back({(m_state == 1) ? 3'(1 << m_g) : 3'b000, m_plot, m_x, m_y, m_c,
                  1'(m_state != 0), m_err});
  end

  always @(negedge clk) begin
    logic [23:0] exp_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      check("cycle", 32'({grant, plot, xout, yout, colourOut, busy, timeoutErr}), 32'(exp_v));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; done = '0; plotIn = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_grant(input logic [2:0] want, input string tag);
    int waited;
    waited = 0;
    while (grant !== want && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check(tag, 32'(grant === want), 32'd1);
  endtask

  initial begin
    int cnt, held, zeros, n;
    logic [2:0] seq[4];
    int gaps[3];

    // Single client
    do_reset();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(timeoutErr), 0);
    xIn = 24'd73; yIn = 21'd105; colourIn = 9'b111; plotIn = 3'b001; req = 3'b001;
    @(negedge clk);
    check("single_grant", 32'(grant), 32'b001);
    @(negedge clk);
    check("single_x", 32'(xout), 73);
    check("single_y", 32'(yout), 105);
    check("single_c", 32'(colourOut), 7);
    check("single_plot", 32'(plot), 1);
    req = '0; plotIn = '0;
    repeat (3) @(negedge clk);

    // Round robin with done after 4 grant cycles
    do_reset();
    req = 3'b111;
    held = 0; zeros = 0; n = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      done = '0;
      if (grant != 3'b000) begin
        if (held == 0) begin
          if (n > 0) gaps[n-1] = zeros;
          seq[n] = grant;
          n++;
        end
        held++;
        zeros = 0;
        if (held == 4) done = grant;
      end else begin
        held = 0;
        zeros++;
      end
    end
    check("rr_count", 32'(n), 4);
    check("rr_seq0", 32'(seq[0]), 32'b001);
    check("rr_seq1", 32'(seq[1]), 32'b010);
    check("rr_seq2", 32'(seq[2]), 32'b100);
    check("rr_seq3", 32'(seq[3]), 32'b001);
    for (int i = 0; i < 3; i++) check("rr_gap", 32'(gaps[i]), 2);
    req = '0; done = '0;
    repeat (8) @(negedge clk);

    // Isolation: client 1 strobes while client 0 owns the port
    do_reset();
    xIn = {8'd0, 8'd50, 8'd20}; plotIn = 3'b010; req = 3'b001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("iso_no50", 32'(xout == 8'd50), 0);
      check("iso_plot", 32'(plot), 0);
    end
    check("iso_x", 32'(xout), 20);
    req = '0; plotIn = '0;
    repeat (3) @(negedge clk);

    // Timeout on client 2, then a normal grant keeps the flag
    do_reset();
    req = 3'b100;
    wait_grant(3'b100, "to_wait");
    cnt = 0;
    while (grant === 3'b100 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    req = '0;
    check("to_cycles", 32'(cnt), TO);
    check("to_err", 32'(timeoutErr), 1);
    @(negedge clk);
    req = 3'b001;
    wait_grant(3'b001, "to_wait2");
    done = 3'b001;
    @(negedge clk);
    done = '0; req = '0;
    check("to_rel_grant", 32'(grant), 0);
    @(negedge clk);
    check("to_err_sticky", 32'(timeoutErr), 1);

    // done and timeout in the same cycle
    do_reset();
    req = 3'b010;
    wait_grant(3'b010, "coll_wait");
    for (int i = 2; i <= TO; i++) begin
      @(negedge clk);
      check("coll_hold", 32'(grant), 32'b010);
    end
    done = 3'b010;
    @(negedge clk);
    done = '0; req = '0;
    check("coll_grant", 32'(grant), 0);
    check("coll_err", 32'(timeoutErr), 0);
    repeat (2) @(negedge clk);

    // Reset in the middle of a grant
    do_reset();
    xIn = 24'h00_63_00; yIn = 21'h1f80; colourIn = 9'o050; plotIn = 3'b010; req = 3'b010;
    wait_grant(3'b010, "mid_wait");
    @(negedge clk);
    check("mid_plot", 32'(plot), 1);
    reset = 1'b1; req = 3'b111;
    @(negedge clk);
    check("mid_vec", 32'({grant, plot, xout, yout, colourOut, busy, timeoutErr}), 0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_first", 32'(grant), 32'b001);
    req = '0; plotIn = '0;
    repeat (3) @(negedge clk);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req      = 3'($urandom_range(0, 7));
      done     = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      plotIn   = 3'($urandom_range(0, 7));
      xIn      = 24'($urandom);
      yIn      = 21'($urandom);
      colourIn = 9'($urandom);
    end
    req = '0; done = '0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16'd20000; maximum cycles one client may hold the grant (covers a 160x120 full-screen clear of 19200 pixels).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  3  per-client draw request; bit0 rocket, bit1 alien block, bit2 bullets.
REQ-005 done  input  3  per-client end-of-drawing pulse; only the granted client's bit is honoured.
REQ-006 plotIn  input  3  per-client pixel-valid strobe.
REQ-007 xIn  input  24  packed 8-bit x coordinates, client k at bits [8k+7:8k].
REQ-008 yIn  input  21  packed 7-bit y coordinates, client k at bits [7k+6:7k].
REQ-009 colourIn  input  9  packed 3-bit colours, client k at bits [3k+2:3k].
REQ-010 grant  output  3  one-hot grant; all zero when no client is granted.
REQ-011 xout  output  8  registered x to the VGA adapter.
REQ-012 yout  output  7  registered y to the VGA adapter.
REQ-013 colourOut  output  3  registered colour to the VGA adapter.
REQ-014 plot  output  1  registered write enable to the VGA adapter.
REQ-015 busy  output  1  high in every state other than IDLE.
REQ-016 timeoutErr  output  1  sticky flag set when a grant is revoked by timeout.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-018 IDLE, no req bit set: SHALL stay in IDLE with grant=0 and plot=0.
REQ-019 IDLE, any req bit set: SHALL select a winner round-robin, searching from client (lastPtr+1) mod 3 upward, and SHALL enter GRANT with grant=onehot(winner) visible in the next cycle.
REQ-020 GRANT, each cycle: xout/yout/colourOut SHALL load the granted client's fields; plot SHALL load plotIn[g]. Latency is 1 cycle from client input to adapter output.
REQ-021 Non-granted clients' plotIn, coordinates and colour SHALL never reach the outputs.
REQ-022 Leaving GRANT: done[g]=1 or req[g]=0 sampled in GRANT SHALL move to RELEASE at the next edge. The pixel presented in that same cycle is still forwarded with the 1-cycle latency.
REQ-023 RELEASE, one cycle: grant=0 and plot=0; lastPtr SHALL be set to g; the FSM SHALL then return to IDLE.
REQ-024 Grant spacing: a new grant SHALL appear no earlier than 2 cycles after grant drops. Back-to-back grants to two different clients therefore have a 2-cycle gap (RELEASE, IDLE).
REQ-025 Hold counter: a 16-bit counter SHALL clear on entry to GRANT and increment each GRANT cycle.
REQ-026 Timeout: when the hold counter equals TIMEOUT-1 and done[g]=0, the FSM SHALL go to RELEASE and set timeoutErr=1.
REQ-027 timeoutErr SHALL stay set until reset.
REQ-028 done[g] and timeout in the same cycle: done wins and timeoutErr SHALL NOT be set.
REQ-029 done bits of non-granted clients SHALL be ignored in all states.
REQ-030 A client whose req stays high after release SHALL be served again only after all other requesting clients have been served once.
REQ-031 grant SHALL be one-hot or zero in every cycle; busy = (state != IDLE).

Reset
REQ-032 Reset, asserted in any state including mid-GRANT, SHALL at the next edge:
- set state to IDLE;
- clear grant, plot, xout, yout, colourOut, busy, timeoutErr and the hold counter;
- set lastPtr=2, so client 0 has first priority.
REQ-033 While reset is high, all inputs SHALL be ignored.

Verification
REQ-034 Single client: reset, then req=001 with xIn[7:0]=73, yIn[6:0]=105, colourIn[2:0]=3'b111, plotIn[0]=1 -> grant=001 one cycle after req is sampled; the cycle after that, xout=73, yout=105, colourOut=7, plot=1.
REQ-035 Round robin: req=111 held high, each client pulses done after 4 grant cycles -> grant sequence 001, 010, 100, 001, with exactly 2 zero-grant cycles between consecutive grants.
REQ-036 Isolation: grant=001, client1 drives plotIn[1]=1 with xIn[15:8]=50 -> plot and xout follow client 0 only; xout never shows 50.
REQ-037 Timeout: TIMEOUT=8, client 2 holds req with no done -> grant drops after 8 GRANT cycles and timeoutErr=1, still 1 after a later normal grant completes.
REQ-038 Done/timeout collision: TIMEOUT=8, done[g] asserted in the 8th GRANT cycle -> RELEASE entered and timeoutErr stays 0.
REQ-039 Reset mid-grant: grant=010 with plot=1, reset pulsed for one cycle -> next cycle grant=000, plot=0, all outputs 0; with req=111 afterwards, the first grant is 001.
